// File: rtl/ddr2_host_issuer.sv
// ddr2_host_issuer: turns host requests into ddr2_controller command/data beats,
// buffering block-write data so the BLW burst never stalls on the host.
module ddr2_host_issuer #(
  parameter int FILL_LIMIT = 63
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_CMD,
  input  logic [1:0]  REQ_SZ,
  input  logic [2:0]  REQ_OP,
  input  logic [24:0] REQ_ADDR,
  input  logic [15:0] REQ_DATA,
  input  logic        REQ_FETCHING,
  input  logic        WD_VALID,
  output logic        WD_READY,
  input  logic [15:0] WD_DATA,
  input  logic        READY,
  input  logic        NOTFULL,
  input  logic [6:0]  FILLCOUNT,
  output logic [2:0]  CMD,
  output logic [1:0]  SZ,
  output logic [2:0]  OP,
  output logic [24:0] ADDR,
  output logic [15:0] DIN,
  output logic        FETCHING,
  output logic        BUSY
);

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_SCR = 3'd1;
  localparam logic [2:0] C_SCW = 3'd2;
  localparam logic [2:0] C_BLR = 3'd3;
  localparam logic [2:0] C_BLW = 3'd4;
  localparam logic [2:0] C_ATR = 3'd5;
  localparam logic [2:0] C_ATW = 3'd6;
  localparam logic [2:0] C_NOP7 = 3'd7;
  localparam logic [31:0] FILL_LIMIT_U = FILL_LIMIT;

  typedef enum logic [2:0] {
    WAIT_RDY,
    IDLE,
    COLLECT,
    ISSUE,
    BLW_DATA
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cmd_reg, cmd_next;
  logic [1:0]  sz_reg, sz_next;
  logic [2:0]  op_reg, op_next;
  logic [24:0] addr_reg, addr_next;
  logic [15:0] din_reg, din_next;
  logic        fetching_reg, fetching_next;
  logic [5:0]  len_reg, len_next;
  logic [5:0]  idx_reg, idx_next;

  logic [15:0] buf_mem [0:31];
  logic [15:0] buf_rd_reg;
  logic [4:0]  rd_addr;

  logic cmd_space, data_space, consumed;
  logic req_fire, wd_fire, req_is_nop, req_is_blw, last_word;
  logic load_req, start_blw, go_idle;

  assign cmd_space  = NOTFULL;
  assign data_space = ({25'd0, FILLCOUNT} <= FILL_LIMIT_U);

  always_comb begin
    consumed = 1'b1;
    case (cmd_reg)
      C_SCR, C_BLR:               consumed = cmd_space;
      C_SCW, C_BLW, C_ATR, C_ATW: consumed = cmd_space && data_space;
      default:                    consumed = 1'b1;
    endcase
  end

  always_comb begin
    REQ_READY = 1'b0;
    case (state_reg)
      IDLE:    REQ_READY = 1'b1;
      ISSUE:   REQ_READY = consumed && (cmd_reg != C_BLW);
      default: REQ_READY = 1'b0;
    endcase
  end

  assign WD_READY   = (state_reg == COLLECT);
  assign req_fire   = REQ_VALID && REQ_READY;
  assign wd_fire    = WD_VALID && WD_READY;
  assign req_is_nop = (REQ_CMD == C_NOP) || (REQ_CMD == C_NOP7);
  assign req_is_blw = (REQ_CMD == C_BLW);
  assign last_word  = (idx_reg == len_reg - 6'd1);

  // The read register always holds buf[idx+1] during ISSUE/BLW_DATA, so the
  // next word is ready the moment the current one is consumed.
  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    sz_next       = sz_reg;
    op_next       = op_reg;
    addr_next     = addr_reg;
    din_next      = din_reg;
    fetching_next = fetching_reg;
    len_next      = len_reg;
    idx_next      = idx_reg;
    rd_addr       = 5'd0;
    load_req      = 1'b0;
    start_blw     = 1'b0;
    go_idle       = 1'b0;

    case (state_reg)
      WAIT_RDY: begin
        if (READY) state_next = IDLE;
      end
      IDLE: begin
        if (req_fire) begin
          if (req_is_blw)       start_blw = 1'b1;
          else if (!req_is_nop) load_req  = 1'b1;
        end
      end
      COLLECT: begin
        if (wd_fire) begin
          idx_next = idx_reg + 6'd1;
          if (last_word) begin
            state_next = ISSUE;
            cmd_next   = C_BLW;
            din_next   = buf_rd_reg;
            idx_next   = 6'd0;
            rd_addr    = 5'd1;
          end
        end
      end
      ISSUE: begin
        rd_addr = idx_reg[4:0] + 5'd1;
        if (consumed) begin
          if (cmd_reg == C_BLW) begin
            state_next = BLW_DATA;
            cmd_next   = C_NOP;
            din_next   = buf_rd_reg;
            idx_next   = 6'd1;
            rd_addr    = 5'd2;
          end else if (req_fire && req_is_blw) begin
            start_blw = 1'b1;
          end else if (req_fire && !req_is_nop) begin
            load_req = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      BLW_DATA: begin
        rd_addr = idx_reg[4:0] + 5'd1;
        if (data_space) begin
          if (last_word) begin
            go_idle = 1'b1;
          end else begin
            idx_next = idx_reg + 6'd1;
            din_next = buf_rd_reg;
            rd_addr  = idx_reg[4:0] + 5'd2;
          end
        end
      end
      default: state_next = WAIT_RDY;
    endcase

    if (load_req) begin
      state_next    = ISSUE;
      cmd_next      = REQ_CMD;
      sz_next       = (REQ_CMD == C_SCR || REQ_CMD == C_SCW) ? 2'd0 : REQ_SZ;
      op_next       = (REQ_CMD == C_ATR || REQ_CMD == C_ATW) ? REQ_OP : 3'd0;
      addr_next     = REQ_ADDR;
      din_next      = (REQ_CMD == C_SCR || REQ_CMD == C_BLR) ? 16'd0 : REQ_DATA;
      fetching_next = REQ_FETCHING;
    end

    if (start_blw) begin
      state_next    = COLLECT;
      cmd_next      = C_NOP;
      sz_next       = REQ_SZ;
      op_next       = 3'd0;
      addr_next     = REQ_ADDR;
      din_next      = 16'd0;
      fetching_next = REQ_FETCHING;
      len_next      = {({1'b0, REQ_SZ} + 3'd1), 3'b000};
      idx_next      = 6'd0;
    end

    if (go_idle) begin
      state_next    = IDLE;
      cmd_next      = C_NOP;
      sz_next       = 2'd0;
      op_next       = 3'd0;
      addr_next     = 25'd0;
      din_next      = 16'd0;
      fetching_next = 1'b0;
      idx_next      = 6'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= WAIT_RDY;
      cmd_reg      <= 3'd0;
      sz_reg       <= 2'd0;
      op_reg       <= 3'd0;
      addr_reg     <= 25'd0;
      din_reg      <= 16'd0;
      fetching_reg <= 1'b0;
      len_reg      <= 6'd0;
      idx_reg      <= 6'd0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      sz_reg       <= sz_next;
      op_reg       <= op_next;
      addr_reg     <= addr_next;
      din_reg      <= din_next;
      fetching_reg <= fetching_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
    end
  end

  // Block-write buffer: plain write port plus registered read for RAM inference.
  always_ff @(posedge CLK) begin
    if (wd_fire) buf_mem[idx_reg[4:0]] <= WD_DATA;
    buf_rd_reg <= buf_mem[rd_addr];
  end

  assign CMD      = cmd_reg;
  assign SZ       = sz_reg;
  assign OP       = op_reg;
  assign ADDR     = addr_reg;
  assign DIN      = din_reg;
  assign FETCHING = fetching_reg;
  assign BUSY     = !(state_reg == IDLE || state_reg == WAIT_RDY) || (cmd_reg != C_NOP);

endmodule

// File: doc/ddr2_host_issuer.md
# ddr2_host_issuer

Upstream request issuer for `ddr2_controller`. It accepts host requests over a valid/ready handshake and drives `CMD`/`SZ`/`OP`/`ADDR`/`DIN`/`FETCHING` into the controller, obeying the controller's command-FIFO (`NOTFULL`) and data-FIFO (`FILLCOUNT`) backpressure. Block-write data is fully buffered before the BLW command is issued, so the data stream to the controller never stalls on the host.

## Interface
- `FILL_LIMIT`, default 63: the data FIFO has space when `FILLCOUNT <= FILL_LIMIT`.
- `CLK` in 1: system clock; all logic on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `REQ_VALID` in 1: host request valid.
- `REQ_READY` out 1: issuer accepts the request this cycle.
- `REQ_CMD` in 3: 0/7 NOP, 1 SCR, 2 SCW, 3 BLR, 4 BLW, 5 ATR, 6 ATW.
- `REQ_SZ` in 2: block size; a block is 8*(SZ+1) words.
- `REQ_OP` in 3: atomic opcode.
- `REQ_ADDR` in 25: controller address.
- `REQ_DATA` in 16: data word for SCW/ATR/ATW.
- `REQ_FETCHING` in 1: forwarded to `FETCHING` with the command.
- `WD_VALID` in 1: block-write data word valid.
- `WD_READY` out 1: block-write word accepted.
- `WD_DATA` in 16: block-write data word.
- `READY` in 1: controller initialisation complete.
- `NOTFULL` in 1: controller command FIFO has space.
- `FILLCOUNT` in 7: controller data FIFO fill level.
- `CMD` out 3, `SZ` out 2, `OP` out 3, `ADDR` out 25, `DIN` out 16, `FETCHING` out 1: registered controller inputs.
- `BUSY` out 1: state is not IDLE/WAIT_RDY, or `CMD` is not 000.

## Operation
- `cmd_space = NOTFULL`; `data_space = (FILLCOUNT <= FILL_LIMIT)`.
- The command on `CMD` is consumed in a cycle when:
  - SCR/BLR: `cmd_space`.
  - SCW/BLW/ATR/ATW: `cmd_space && data_space`.
  - 000: always.
- Output fields not used by the driven command are 0:
  - SCR: SZ, OP, DIN = 0.
  - SCW: SZ, OP = 0.
  - BLR: OP, DIN = 0.
  - BLW: OP = 0.
- WAIT_RDY (reset state): all outputs 0. Moves to IDLE when `READY` is sampled as 1. `READY` is ignored in every other state.
- IDLE: `CMD = 000`, `REQ_READY = 1`. On handshake:
  - NOP: dropped; stay in IDLE.
  - BLW: latch ADDR/SZ/FETCHING, set `len = 8*(SZ+1)` (6 bits, 8..32), clear the word counter, go to COLLECT.
  - Otherwise: load the outputs, go to ISSUE.
- COLLECT: `WD_READY = 1`, one word per handshake into a 32x16 buffer.
  - After word `len-1` is captured, go to ISSUE with `CMD = 100` and `DIN = buf[0]`.
  - `REQ_READY = 0`.
- ISSUE: hold all outputs until consumed.
  - `REQ_READY = consumed && CMD != 100`.
  - Consumed with a handshake on a non-NOP, non-BLW request: load that request directly (back-to-back issue).
  - Consumed with a BLW request: go to COLLECT.
  - Consumed with no request: `CMD = 000`, go to IDLE.
  - Consumed BLW: go to BLW_DATA with `CMD = 000`, `DIN = buf[1]`, `idx = 1`.
- BLW_DATA: `CMD = 000`, ADDR/SZ held.
  - Each `data_space` cycle consumes `DIN`: `idx++` and `DIN = buf[idx]`.
  - After `buf[len-1]` is consumed, go to IDLE with `DIN = 0`.
  - Without `data_space`, `DIN` holds.
  - `REQ_READY = WD_READY = 0`.
- `RESET` in any state clears the buffer pointers and returns to WAIT_RDY. Outputs read 0 from the next edge; a partially sent block is abandoned.

## Timing
- All outputs are registered. Request handshake at edge k makes the command visible on `CMD` from k+1.
- Throughput is one consumed command per cycle with `REQ_VALID` held and no backpressure.
- BLW latency: `len` WD handshakes, then `CMD = 100` on the next cycle, then `len-1` data cycles. Minimum BLW occupancy is 2*len cycles from request to IDLE.
- Consumption is evaluated on the current registered outputs against the same-cycle `NOTFULL`/`FILLCOUNT`.
- `FILLCOUNT = FILL_LIMIT` counts as space; `FILL_LIMIT + 1` does not.
- `REQ_READY` and `WD_READY` are never both 1.

## Test plan
- Reset and init: `RESET` for 3 cycles, `READY = 0` for 10 cycles -> `REQ_READY = 0`, `CMD = 000`. Raise `READY` -> `REQ_READY = 1` one cycle later.
- SCW, ADDR 0x008F07A, data 0xFACE, `FILLCOUNT = 10`, `NOTFULL = 1` -> one cycle of `CMD = 010`, `ADDR = 0x008F07A`, `DIN = FACE`, then `CMD = 000`.
- Backpressure:
  - SCW with `FILLCOUNT = 64` for 5 cycles -> `CMD = 010` held for 6 cycles.
  - SCR with `FILLCOUNT = 64`, `NOTFULL = 1` -> consumed in 1 cycle.
  - `NOTFULL = 0` for 3 cycles -> SCR held for 4 cycles.
- BLW, `SZ = 1`, WD words 0x1000..0x100F -> `CMD = 100` with `DIN = 1000`, then 15 cycles of `CMD = 000` with `DIN` 1001..100F. `FILLCOUNT = 64` for 2 cycles mid-stream -> `DIN` holds 2 extra cycles and no word is skipped.
- Four SCR requests back-to-back at addresses 0, 8, 16, 24 with `REQ_VALID` held -> `CMD = 001` on 4 consecutive cycles, addresses in order.
- `RESET` during BLW_DATA at idx 5 -> next cycle `CMD = 000`, `DIN = 0`, `REQ_READY = 0` until `READY` is sampled. A new BLW after that restarts from word 0.
